// File: rtl/sw_reader_pkg.sv
// -----------------------------------------------------------------------------
// sw_reader_pkg
// Shared types and default parameters for the slide-switch binary reader.
//   rd_state_t   : debounce FSM state encoding
//   DEF_WIDTH    : default number of switch bits
//   DEF_DEBOUNCE : default stable-cycle count before a value is committed
// -----------------------------------------------------------------------------
package sw_reader_pkg;

    typedef enum logic {
        IDLE,
        COUNT
    } rd_state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_DEBOUNCE = 500000;

endpackage

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Two-flop synchroniser for a bus of independent asynchronous levels. Each bit
// is synchronised on its own, so a multi-bit change may land over more than
// one cycle; downstream logic must tolerate that (the debouncer does).
// Ports:
//   clock    : destination clock
//   reset_n  : asynchronous active-low reset, both stages clear to 0
//   async_i  : asynchronous input levels
//   sync_o   : synchronised levels (second flop stage)
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sw_bin_reader.sv
// -----------------------------------------------------------------------------
// sw_bin_reader
// Reads slide switches, synchronises and debounces them, and hands each newly
// settled value to a consumer over a valid/ready handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | synchronised switches equal the committed value, nothing to do
//   COUNT | a different value is being qualified for DEBOUNCE_CYCLES cycles
//
// Ports:
//   clock     : system clock
//   reset_n   : asynchronous active-low reset
//   sw_in     : raw switch levels (asynchronous, may bounce)
//   out_ready : consumer accepts bin_out when high together with out_valid
//   bin_out   : last committed debounced value
//   out_valid : a committed value is waiting to be accepted
//   overrun   : sticky, a commit replaced a value that was never accepted
//   busy      : a change is being qualified (state is COUNT)
// -----------------------------------------------------------------------------
module sw_bin_reader
    import sw_reader_pkg::*;
#(
    parameter  int WIDTH           = DEF_WIDTH,
    parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] bin_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             overrun_q;
    rd_state_t        state_q;

    bit_synchronizer #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .async_i (sw_in),
        .sync_o  (sync_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A transfer drops valid; a commit later in this block re-asserts it.
            if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (sync_q != bin_q) begin
                        state_q <= COUNT;
                        cand_q  <= sync_q;
                        cnt_q   <= '0;
                    end
                end
                COUNT: begin
                    if (sync_q == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            bin_q   <= cand_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            // Only a value that is not being taken this edge is lost.
                            if (valid_q && !out_ready) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (sync_q == bin_q) begin
                        // Bounced back to the committed value: abandon quietly.
                        state_q <= IDLE;
                    end else begin
                        cand_q <= sync_q;
                        cnt_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == COUNT);

endmodule
